// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and a lock indication from an incoming VGA sync/colour stream.
// Coordinates free-run and are re-aligned by sync leading edges; timing errors drop lock.
module vga_sync_decoder #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int SYNC_POL = 1
) (
  input  logic        i_pix_clk,
  input  logic        i_reset_n,
  input  logic        i_horz_sync,
  input  logic        i_vert_sync,
  input  logic [2:0]  i_red,
  input  logic [2:0]  i_green,
  input  logic [1:0]  i_blue,
  output logic [15:0] o_horz_coord,
  output logic [15:0] o_vert_coord,
  output logic        o_pix_valid,
  output logic [2:0]  o_red,
  output logic [2:0]  o_green,
  output logic [1:0]  o_blue,
  output logic        o_frame_start,
  output logic        o_locked,
  output logic        o_sync_err,
  output logic [7:0]  o_err_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
  localparam logic [15:0] H_LOAD = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] V_LOAD = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
  localparam logic        POL    = (SYNC_POL != 0);

  typedef enum logic [1:0] {SEARCH, H_ACQ, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        hs_prev_q, vs_prev_q;
  logic [1:0]  good_q, good_d;
  logic        valid_q, valid_d;
  logic [2:0]  red_q, red_d, green_q, green_d;
  logic [1:0]  blue_q, blue_d;
  logic        fs_q, fs_d;
  logic        locked_q;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        hs_now, vs_now, h_edge, v_edge;
  logic        x_wrap, h_on_time;
  logic [15:0] x_run, y_run;

  always_comb begin
    hs_now    = (i_horz_sync == POL);
    vs_now    = (i_vert_sync == POL);
    h_edge    = hs_now && !hs_prev_q;
    v_edge    = vs_now && !vs_prev_q;
    x_wrap    = (x_q == H_LAST);
    x_run     = x_wrap ? 16'd0 : x_q + 16'd1;
    y_run     = x_wrap ? ((y_q == V_LAST) ? 16'd0 : y_q + 16'd1) : y_q;
    h_on_time = (x_run == H_LOAD);
    // Edge-driven loads win over free-running, regardless of lock state
    x_d       = h_edge ? H_LOAD : x_run;
    y_d       = v_edge ? V_LOAD : y_run;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    case (state_q)
      SEARCH: begin
        if (h_edge) begin
          state_d = H_ACQ;
          good_d  = 2'd0;
        end
      end
      H_ACQ: begin
        if (h_edge) begin
          good_d = h_on_time ? ((good_q == 2'd2) ? 2'd2 : good_q + 2'd1) : 2'd0;
        end
        if (v_edge && good_q == 2'd2) state_d = LOCKED;
      end
      LOCKED: begin
        // Covers both a misplaced H-edge and a missing one at the expected position
        err_d = (h_edge != h_on_time) ||
                (v_edge && (y_run != V_LOAD || x_run != 16'd0));
        if (err_d) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    valid_d   = (state_d == LOCKED) && (x_d < H_ACT) && (y_d < V_ACT);
    fs_d      = (state_d == LOCKED) && (x_d == 16'd0) && (y_d == 16'd0);
    red_d     = valid_d ? i_red   : 3'd0;
    green_d   = valid_d ? i_green : 3'd0;
    blue_d    = valid_d ? i_blue  : 2'd0;
    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= SEARCH;
      x_q       <= '0;
      y_q       <= '0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      good_q    <= '0;
      valid_q   <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      fs_q      <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      hs_prev_q <= hs_now;
      vs_prev_q <= vs_now;
      good_q    <= good_d;
      valid_q   <= valid_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      fs_q      <= fs_d;
      locked_q  <= (state_d == LOCKED);
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_horz_coord  = x_q;
  assign o_vert_coord  = y_q;
  assign o_pix_valid   = valid_q;
  assign o_red         = red_q;
  assign o_green       = green_q;
  assign o_blue        = blue_q;
  assign o_frame_start = fs_q;
  assign o_locked      = locked_q;
  assign o_sync_err    = err_q;
  assign o_err_count   = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down raster (25x13) so that
// multi-frame and 300-relock scenarios stay short; structure matches 800x600 timing.
module tb_vga_sync_decoder;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int HL = HA + HF;
  localparam int VL = VA + VF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync = 1'b0, vsync = 1'b0;
  logic [2:0]  red_in = '0, green_in = '0;
  logic [1:0]  blue_in = '0;
  logic [15:0] o_horz_coord, o_vert_coord;
  logic        o_pix_valid, o_frame_start, o_locked, o_sync_err;
  logic [2:0]  o_red, o_green;
  logic [1:0]  o_blue;
  logic [7:0]  o_err_count;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1)
  ) dut (
    .i_pix_clk(clk), .i_reset_n(rst_n),
    .i_horz_sync(hsync), .i_vert_sync(vsync),
    .i_red(red_in), .i_green(green_in), .i_blue(blue_in),
    .o_horz_coord(o_horz_coord), .o_vert_coord(o_vert_coord),
    .o_pix_valid(o_pix_valid),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_frame_start(o_frame_start), .o_locked(o_locked),
    .o_sync_err(o_sync_err), .o_err_count(o_err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] gx = '0, gy = '0, cur_x = '0, cur_y = '0;
  logic        exp_locked = 1'b0, pending = 1'b0, seen_lock = 1'b0;
  logic [15:0] rise_x = '0, rise_y = '0;
  int lock_bad, coord_bad, valid_bad, colour_bad, red_bad, fs_bad;
  int vcount, fscount, errs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic logic ideal_hs(input logic [15:0] x);
    return (x >= 16'(HL)) && (x < 16'(HL + HS));
  endfunction

  function automatic logic ideal_vs(input logic [15:0] y);
    return (y >= 16'(VL)) && (y < 16'(VL + VS));
  endfunction

  // Drives one sample for raster position (gx,gy), then advances the raster.
  task automatic apply(input logic hs, input logic vs);
    hsync    = hs;
    vsync    = vs;
    red_in   = gx[2:0];
    green_in = gy[2:0];
    blue_in  = gx[4:3];
    @(negedge clk);
    cur_x = gx;
    cur_y = gy;
    if (gx == 16'(HT - 1)) begin
      gx = '0;
      gy = (gy == 16'(VT - 1)) ? 16'd0 : gy + 16'd1;
    end else begin
      gx = gx + 16'd1;
    end
  endtask

  task automatic clear_stats();
    lock_bad = 0; coord_bad = 0; valid_bad = 0; colour_bad = 0; red_bad = 0;
    fs_bad = 0; vcount = 0; fscount = 0; errs = 0;
    seen_lock = 1'b0; rise_x = 16'hFFFF; rise_y = 16'hFFFF;
  endtask

  // Ideal timing; lock is expected exactly at the first V-edge position while pending.
  task automatic drive_ideal(input int n);
    logic       ev, efs;
    logic [7:0] exp_col;
    for (int i = 0; i < n; i++) begin
      apply(ideal_hs(gx), ideal_vs(gy));
      if (pending && cur_x == 16'd0 && cur_y == 16'(VL)) begin
        exp_locked = 1'b1;
        pending    = 1'b0;
      end
      if (o_locked !== exp_locked) lock_bad++;
      if (o_locked === 1'b1 && !seen_lock) begin
        seen_lock = 1'b1;
        rise_x    = o_horz_coord;
        rise_y    = o_vert_coord;
      end
      ev  = exp_locked && (cur_x < 16'(HA)) && (cur_y < 16'(VA));
      efs = exp_locked && (cur_x == 16'd0) && (cur_y == 16'd0);
      if (exp_locked && (o_horz_coord !== cur_x || o_vert_coord !== cur_y)) coord_bad++;
      if (o_pix_valid !== ev) valid_bad++;
      exp_col = ev ? {cur_x[2:0], cur_y[2:0], cur_x[4:3]} : 8'd0;
      if ({o_red, o_green, o_blue} !== exp_col) colour_bad++;
      if (o_pix_valid === 1'b1 && o_red !== cur_x[2:0]) red_bad++;
      if (o_frame_start !== efs) fs_bad++;
      if (o_pix_valid === 1'b1) vcount++;
      if (o_frame_start === 1'b1) fscount++;
      if (o_sync_err === 1'b1) errs++;
    end
  endtask

  initial begin
    int lock_seen, err_seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_locked", o_locked, 0);
    check("rst_err_count", o_err_count, 0);
    check("rst_coords", {o_horz_coord, o_vert_coord}, 0);
    check("rst_valid", o_pix_valid, 0);
    check("rst_sync_err", o_sync_err, 0);
    rst_n = 1'b1;

    // Frame 0: acquisition, lock at first V-edge after two good lines
    gx = '0; gy = '0; exp_locked = 1'b0; pending = 1'b1;
    clear_stats();
    drive_ideal(HT * VT);
    check("acq_lock_timing", lock_bad, 0);
    check("acq_rise_x", rise_x, 0);
    check("acq_rise_y", rise_y, VL);
    check("acq_no_err", errs, 0);
    check("acq_locked_end", o_locked, 1);

    // Frame 1: fully locked ideal frame
    clear_stats();
    drive_ideal(HT * VT);
    check("frame_valid_count", vcount, HA * VA);
    check("frame_start_count", fscount, 1);
    check("frame_no_err", errs, 0);
    check("frame_coord", coord_bad, 0);
    check("frame_valid_map", valid_bad, 0);
    check("frame_colour", colour_bad, 0);
    check("frame_red_eq_x", red_bad, 0);
    check("frame_fs_pos", fs_bad, 0);
    check("frame_lock", lock_bad, 0);

    // Frame 2: hsync on line 3 delayed by 3 cycles
    clear_stats();
    drive_ideal(3 * HT + HL);
    check("pre_delay_ok", errs + lock_bad + coord_bad, 0);
    apply(1'b0, 1'b0);
    check("miss_sync_err", o_sync_err, 1);
    check("miss_err_count", o_err_count, 1);
    check("miss_unlocked", o_locked, 0);
    apply(1'b0, 1'b0);
    check("miss_err_one_cycle", o_sync_err, 0);
    apply(1'b0, 1'b0);
    apply(1'b1, 1'b0);
    check("late_edge_reload", o_horz_coord, HL);
    repeat (3) apply(1'b1, 1'b0);
    exp_locked = 1'b0; pending = 1'b1;
    clear_stats();
    drive_ideal(HL);
    check("shifted_x", o_horz_coord, HL - 4);
    apply(1'b1, 1'b0);
    check("next_line_reload", o_horz_coord, HL);
    drive_ideal(HT * VT - (4 * HT + HL + 1));
    check("relock_timing", lock_bad, 0);
    check("relock_no_err", errs, 0);
    check("relock_locked", o_locked, 1);
    check("relock_err_count", o_err_count, 1);

    // Frame 3: vsync on the last active line
    clear_stats();
    drive_ideal((VA - 1) * HT);
    check("pre_vs_ok", errs + lock_bad, 0);
    apply(1'b0, 1'b1);
    check("early_vs_err", o_sync_err, 1);
    check("early_vs_unlock", o_locked, 0);
    check("early_vs_y_load", o_vert_coord, VL);
    check("early_vs_x", o_horz_coord, 0);
    check("early_vs_count", o_err_count, 2);

    // 300 quick lock/error cycles to saturate the error counter
    lock_seen = 0;
    err_seen  = 0;
    for (int it = 0; it < 300; it++) begin
      apply(1'b0, 1'b0);
      apply(1'b0, 1'b0);
      for (int p = 0; p < 3; p++) begin
        if (p > 0) repeat (HT - 1) apply(1'b0, 1'b0);
        apply(1'b1, 1'b0);
      end
      apply(1'b0, 1'b1);
      if (o_locked === 1'b1) lock_seen++;
      for (int k = 0; k < 40; k++) begin
        apply(1'b0, 1'b0);
        if (o_sync_err === 1'b1) begin
          err_seen++;
          break;
        end
      end
      if (it == 99) check("sat_mid_count", o_err_count, 102);
    end
    check("sat_locks", lock_seen, 300);
    check("sat_err_pulses", err_seen, 300);
    check("sat_count", o_err_count, 255);
    check("sat_unlocked", o_locked, 0);

    // Lock again, then reset in the middle of an active line
    gx = '0; gy = '0; exp_locked = 1'b0; pending = 1'b1;
    clear_stats();
    drive_ideal(HT * VT + 3 * HT + 5);
    check("prereset_lock", lock_bad, 0);
    check("prereset_locked", o_locked, 1);
    check("prereset_valid", o_pix_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_locked", o_locked, 0);
    check("arst_coords", {o_horz_coord, o_vert_coord}, 0);
    check("arst_valid", o_pix_valid, 0);
    check("arst_colour", {o_red, o_green, o_blue}, 0);
    check("arst_fs_err", {o_frame_start, o_sync_err}, 0);
    check("arst_err_count", o_err_count, 0);
    apply(ideal_hs(gx), ideal_vs(gy));
    rst_n = 1'b1;
    exp_locked = 1'b0; pending = 1'b1;
    clear_stats();
    drive_ideal(175);
    check("post_rst_lock_timing", lock_bad, 0);
    check("post_rst_rise_y", rise_y, VL);
    check("post_rst_locked", o_locked, 1);
    check("post_rst_err_count", o_err_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameters H_ACTIVE 800, H_FP 40, H_SYNC 128, H_BP 88, V_ACTIVE 600, V_FP 1, V_SYNC 4, V_BP 23, SYNC_POL 1; H_TOTAL=1056, V_TOTAL=628 derived.
REQ-002 SHALL have ports, one per line:
- i_pix_clk  in  1  pixel clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_horz_sync, i_vert_sync  in  1 each  incoming syncs; asserted when level == SYNC_POL.
- i_red, i_green, i_blue  in  3/3/2  incoming pixel colour.
- o_horz_coord, o_vert_coord  out  16 each  recovered coordinate of the output pixel.
- o_pix_valid  out  1  recovered pixel lies in the active area.
- o_red, o_green, o_blue  out  3/3/2  captured colour.
- o_frame_start  out  1  pulse on pixel (0,0).
- o_locked  out  1  decoder is locked.
- o_sync_err  out  1  timing-error pulse.
- o_err_count  out  8  saturating error count.

Function
REQ-003 SHALL register every output on i_pix_clk; latency 1: inputs sampled at edge N appear with their coordinate after edge N.
REQ-004 SHALL hold a previous-sample register per sync input.
REQ-005 SHALL define an H-edge as current i_horz_sync asserted while the previous sample was deasserted; V-edge likewise for i_vert_sync.
REQ-006 SHALL free-run the coordinates:
- x_next = x+1, wrapping from H_TOTAL-1 to 0.
- On x wrap, y_next = y+1, wrapping from V_TOTAL-1 to 0.
REQ-007 SHALL load x = H_ACTIVE+H_FP (840) on an H-edge, overriding REQ-006.
REQ-008 SHALL load y = V_ACTIVE+V_FP (601) on a V-edge, overriding REQ-006; x still follows REQ-006/007.
REQ-009 SHALL implement a 3-state machine with states SEARCH, H_ACQ and LOCKED.
REQ-010 SEARCH: first H-edge -> H_ACQ with good-line count 0.
REQ-011 H_ACQ, on each H-edge:
- If x_next==840, increment good-line count; otherwise clear it.
- Once good-line count reaches 2, the next V-edge -> LOCKED.
REQ-012 LOCKED, each of the following is an error:
- H-edge with x_next != 840.
- A cycle where x_next==840 but no H-edge occurs.
- V-edge with y_next != 601 or x_next != 0.
REQ-013 On any REQ-012 error, SHALL:
- pulse o_sync_err for exactly 1 cycle;
- increment o_err_count, saturating at 255;
- go to SEARCH in the same cycle.
REQ-014 Coordinate loads (REQ-007/008) SHALL still apply in the error cycle.
REQ-015 o_locked SHALL be 1 exactly while the state is LOCKED; it first reads 1 with the coordinate loaded by the locking V-edge.
REQ-016 o_pix_valid SHALL be 1 iff o_locked and x<H_ACTIVE and y<V_ACTIVE.
REQ-017 o_red/o_green/o_blue SHALL equal the sampled colour when valid and 0 otherwise.
REQ-018 o_frame_start SHALL be a 1-cycle pulse when locked and the output coordinate is (0,0).
REQ-019 Simultaneous H-edge and V-edge SHALL apply both loads; error checks apply independently.
REQ-020 Coordinates SHALL be unsigned, zero-extended to 16 bits.

Reset
REQ-021 i_reset_n low SHALL immediately, asynchronously:
- clear all outputs, coordinates, previous-sample registers, good-line count and o_err_count;
- set the state to SEARCH.
REQ-022 Reset asserted mid-frame SHALL discard lock; after release, reacquisition per REQ-010/011 is required.
REQ-023 Release SHALL be synchronous to i_pix_clk edges; the first sampled edge after release is the first evaluated.

Verification
REQ-024 Bench SHALL cover these directed scenarios:
- Drive ideal 800x600 timing for 2 frames -> o_locked rises at the first V-edge following 2 good H-edges.
- Locked, ideal timing -> o_pix_valid high for 480000 cycles per frame, o_frame_start once per 663168 cycles, o_sync_err never set.
- Locked, colour = x[2:0] -> o_red equals o_horz_coord[2:0] whenever valid; all colour outputs 0 in blanking.
- Locked, one hsync delayed 3 cycles -> one missing-sync error, o_err_count=1, state SEARCH; next line H-edge reloads x=840.
- Locked, vsync asserted on line 599 -> o_sync_err pulse, o_locked drops; 300 forced errors -> o_err_count stays 255.
- Reset pulse mid-line while locked -> all outputs 0 immediately; lock is regained only after 2 good lines plus a V-edge.
